bin_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one bit per clock instead of unrolling the whole conversion combinationally. It supports arbitrary input width and digit count, uses a start/busy/done handshake, and flags overflow when the value does not fit in DIGITS decimal digits. It feeds the seven-segment display path of the frequency counter, and wide count values (16 bits and up) make a combinational converter too deep.

---
 rtl/bin_bcd_seq_if.sv | 15 +
 rtl/bin_bcd_seq.sv | 87 ++++++++
 2 files changed

// File: rtl/bin_bcd_seq_if.sv
// bin_bcd_seq_if: start/busy/done handshake and result bus of the binary-to-BCD converter
interface bin_bcd_seq_if #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, output binary, input busy, input done, input bcd, input overflow);
    modport slave  (input start, input binary, output busy, output done, output bcd, output overflow);
endinterface

// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: sequential double-dabble binary-to-BCD converter, one input bit per clock
module bin_bcd_seq #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input logic          clk,
    input logic          rst_n,
    bin_bcd_seq_if.slave bus
);
    localparam int W  = 4 * DIGITS + BIN_WIDTH;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIN_WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        sr_q, sr_d, adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;

    // next-state: load on accepted start, then add-3 / shift once per cycle until all bits consumed
    always_comb begin
        adj = sr_q;
        for (int k = 0; k < DIGITS; k++)
            adj[BIN_WIDTH+4*k +: 4] = (sr_q[BIN_WIDTH+4*k +: 4] >= 4'd5) ? sr_q[BIN_WIDTH+4*k +: 4] + 4'd3 : sr_q[BIN_WIDTH+4*k +: 4];
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                sr_d    = {{(4*DIGITS){1'b0}}, bus.binary};
                cnt_d   = '0;
                acc_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
        end else begin
            sr_d  = {adj[W-2:0], 1'b0};
            acc_d = acc_q | adj[W-1];
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CNT_LAST) begin
                bcd_d   = sr_d[W-1 -: 4*DIGITS];
                ovf_d   = acc_d;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // state registers; reset aborts any conversion without a done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule
